sram_port_arbiter: RTL and testbench

Shares one single-port synchronous SRAM between the instruction-fetch requester (IF stage) and the data requester (EX stage), for targets that expose a unified memory rather than separate instruction and data SRAMs. The data side has priority, bounded by a starvation guard so fetch always makes progress. The block tracks the owner of each in-flight read and routes read data back to that requester. It raises a stall request toward CTRL whenever a requester is denied in a cycle.

---
 rtl/sram_port_arbiter_pkg.sv | 12 +
 rtl/sram_port_arbiter_starve_cnt.sv | 31 +++
 rtl/sram_port_arbiter.sv | 98 +++++++++
 tb/tb_sram_port_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the unified-SRAM port arbiter: response owner encoding and starvation counter width.
package sram_port_arbiter_pkg;

    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } own_e;

endpackage

// File: rtl/sram_port_arbiter_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles; hit raises fetch priority.
// Registered count, hit is combinational from it; no flow control of its own.
module sram_arb_starve_cnt
    import sram_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == CNT_MAX);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between fetch and data requesters; 0-cycle grant, 1-cycle read response.
// Data has priority until fetch has been denied STARVE_MAX cycles; any denial raises stallreq.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic [DATA_W/8-1:0] d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stallreq
);

    own_e              resp_own;
    logic              starve_hit;
    logic              d_read_gnt;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // Fetch only loses to data while it has not yet been starved out.
    assign i_gnt      = i_req & (~d_req | starve_hit);
    assign d_gnt      = d_req & ~i_gnt;
    assign d_read_gnt = d_gnt & (d_wen == '0);
    assign stallreq   = (i_req & ~i_gnt) | (d_req & ~d_gnt);

    always_comb begin
        mem_en    = 1'b0;
        mem_wen   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (i_gnt) begin
            mem_en   = rst;
            mem_addr = i_addr;
        end else if (d_gnt) begin
            mem_en    = rst;
            mem_wen   = d_wen;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    sram_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (i_req & ~i_gnt),
        .clr (~i_req | i_gnt),
        .hit (starve_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_own <= OWN_NONE;
        end else if (i_gnt) begin
            resp_own <= OWN_INST;
        end else if (d_read_gnt) begin
            resp_own <= OWN_DATA;
        end else begin
            resp_own <= OWN_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (resp_own == OWN_INST) i_rdata_q <= mem_rdata;
            if (resp_own == OWN_DATA) d_rdata_q <= mem_rdata;
        end
    end

    // Response data is forwarded straight from the SRAM, then held for later cycles.
    assign i_rvalid = (resp_own == OWN_INST);
    assign d_rvalid = (resp_own == OWN_DATA);
    assign i_rdata  = i_rvalid ? mem_rdata : i_rdata_q;
    assign d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a transaction-level reference model.
module tb_sram_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WB = DW / 8;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic [WB-1:0] d_wen = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic [WB-1:0] mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          stallreq;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stallreq  (stallreq)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Unwritten locations read back a recognisable function of their address.
    function automatic logic [DW-1:0] seed(input logic [AW-1:0] a);
        return a ^ 32'hDEAD0000;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [WB-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < WB; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Behavioural single-port SRAM driven by the DUT.
    logic [DW-1:0] sram [logic [AW-1:0]];
    logic [DW-1:0] sram_tmp;

    always @(posedge clk) begin
        if (mem_en) begin
            sram_tmp = sram.exists(mem_addr) ? sram[mem_addr] : seed(mem_addr);
            if (mem_wen != '0) sram[mem_addr] = merge(sram_tmp, mem_wdata, mem_wen);
            else mem_rdata <= sram_tmp;
        end
    end

    // Reference model: shadow memory plus pending-response owner and expected data.
    logic [DW-1:0] shd [logic [AW-1:0]];
    int            m_cnt = 0;
    int            m_pend = 0;
    logic [DW-1:0] m_pend_data = '0;
    logic [DW-1:0] m_i_rdata = '0;
    logic [DW-1:0] m_d_rdata = '0;
    logic          e_ig, e_dg;
    logic [DW-1:0] shd_old;

    always @(negedge clk) begin
        if (!rst) begin
            m_cnt = 0; m_pend = 0; m_i_rdata = '0; m_d_rdata = '0;
            e_ig = i_req && !d_req;
            e_dg = d_req;
            chk("rst_mem_en", mem_en, 0);
            chk("rst_i_gnt", i_gnt, e_ig);
            chk("rst_d_gnt", d_gnt, e_dg);
            chk("rst_i_rvalid", i_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
        end else begin
            e_ig = i_req && (!d_req || m_cnt == SM);
            e_dg = d_req && !e_ig;
            chk("m_i_gnt", i_gnt, e_ig);
            chk("m_d_gnt", d_gnt, e_dg);
            chk("m_stallreq", stallreq, (i_req && !e_ig) || (d_req && !e_dg));
            chk("m_mem_en", mem_en, e_ig || e_dg);
            chk("m_mem_wen", mem_wen, e_dg ? d_wen : '0);
            chk("m_mem_addr", mem_addr, e_ig ? i_addr : (e_dg ? d_addr : '0));
            chk("m_mem_wdata", mem_wdata, e_dg ? d_wdata : '0);
            if (m_pend == 1) m_i_rdata = m_pend_data;
            if (m_pend == 2) m_d_rdata = m_pend_data;
            chk("m_i_rvalid", i_rvalid, m_pend == 1);
            chk("m_d_rvalid", d_rvalid, m_pend == 2);
            chk("m_i_rdata", i_rdata, m_i_rdata);
            chk("m_d_rdata", d_rdata, m_d_rdata);

            if (!i_req || e_ig) m_cnt = 0;
            else if (m_cnt < SM) m_cnt++;
            m_pend = 0;
            if (e_ig) begin
                m_pend = 1;
                m_pend_data = shd.exists(i_addr) ? shd[i_addr] : seed(i_addr);
            end else if (e_dg) begin
                shd_old = shd.exists(d_addr) ? shd[d_addr] : seed(d_addr);
                if (d_wen == '0) begin
                    m_pend = 2;
                    m_pend_data = shd_old;
                end else begin
                    shd[d_addr] = merge(shd_old, d_wdata, d_wen);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int   first_gnt;
    logic gnt_dg, gnt_st, ig_now, dg_now;

    initial begin
        #1 rst = 1'b0;
        cyc(); cyc();
        rst = 1'b1;

        // Fetch-only back-to-back reads.
        cyc(); i_req = 1'b1; i_addr = 32'h100; #3 chk("f_gnt0", i_gnt, 1);
        cyc(); i_addr = 32'h104; #3 chk("f_rv0", i_rvalid, 1); chk("f_rd0", i_rdata, 32'hDEAD0100);
        cyc(); i_addr = 32'h108; #3 chk("f_rd1", i_rdata, 32'hDEAD0104); chk("f_stall", stallreq, 0);
        cyc(); i_req = 1'b0; #3 chk("f_rd2", i_rdata, 32'hDEAD0108);
        cyc(); #3 chk("f_rv_idle", i_rvalid, 0); chk("f_hold", i_rdata, 32'hDEAD0108);

        // Simultaneous requests: data wins.
        cyc(); i_req = 1'b1; i_addr = 32'h10C; d_req = 1'b1; d_wen = '0; d_addr = 32'h200;
        #3 chk("c_dgnt", d_gnt, 1); chk("c_ignt", i_gnt, 0); chk("c_stall", stallreq, 1);
        cyc(); d_req = 1'b0;
        #3 chk("c_drv", d_rvalid, 1); chk("c_drd", d_rdata, 32'hDEAD0200);
        chk("c_ihold", i_rdata, 32'hDEAD0108); chk("c_ignt2", i_gnt, 1);
        cyc(); i_req = 1'b0; #3 chk("c_ird", i_rdata, 32'hDEAD010C);

        // Starvation guard under continuous data traffic.
        cyc(); i_req = 1'b1; i_addr = 32'h400; d_req = 1'b1; d_addr = 32'h500;
        first_gnt = -1; gnt_dg = 1'b1; gnt_st = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #3;
            ig_now = i_gnt; dg_now = d_gnt;
            if (ig_now && first_gnt < 0) begin
                first_gnt = k; gnt_dg = d_gnt; gnt_st = stallreq;
            end
            cyc();
            if (ig_now) i_req = 1'b0;
            if (dg_now) d_addr = d_addr + 32'h4;
        end
        d_req = 1'b0;
        chk("s_first_gnt", first_gnt, 4);
        chk("s_dgnt_at_gnt", gnt_dg, 0);
        chk("s_stall_at_gnt", gnt_st, 1);
        cyc(); #3 chk("s_cnt_clr", dut.u_starve.cnt, 0);

        // Partial write then read-back of the same word.
        cyc(); d_req = 1'b1; d_wen = 4'b0011; d_addr = 32'h300; d_wdata = 32'hAABBCCDD;
        #3 chk("w_gnt", d_gnt, 1);
        cyc(); d_wen = '0; d_wdata = '0; #3 chk("w_norv", d_rvalid, 0);
        cyc(); d_req = 1'b0; #3 chk("w_rv", d_rvalid, 1); chk("w_rd", d_rdata, 32'hDEADCCDD);
        cyc(); #3 chk("w_rv_end", d_rvalid, 0);

        // Reset while a fetch read is outstanding.
        cyc(); i_req = 1'b1; i_addr = 32'h600;
        #1 chk("r_gnt", i_gnt, 1);
        #1 rst = 1'b0; i_req = 1'b0;
        cyc(); rst = 1'b1;
        #3 chk("r_norv", i_rvalid, 0); chk("r_irdata", i_rdata, 0);
        chk("r_drdata", d_rdata, 0); chk("r_cnt", dut.u_starve.cnt, 0);
        cyc(); #3 chk("r_norv2", i_rvalid, 0);
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
